// File: rtl/bus_control_sequencer_pkg.sv
// Shared encodings for the hardwired bus control sequencer: bus source selects,
// opcodes and the sequencer state enumeration.
package bus_ctrl_pkg;

    localparam logic [4:0] BUS_R0    = 5'd0;
    localparam logic [4:0] BUS_HI    = 5'd16;
    localparam logic [4:0] BUS_LO    = 5'd17;
    localparam logic [4:0] BUS_ZLOW  = 5'd18;
    localparam logic [4:0] BUS_ZHIGH = 5'd19;
    localparam logic [4:0] BUS_PC    = 5'd20;
    localparam logic [4:0] BUS_MDR   = 5'd21;
    localparam logic [4:0] BUS_NONE  = 5'd22;
    localparam logic [4:0] BUS_CSIGN = 5'd23;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_ADDI = 5'd4;
    localparam logic [4:0] OP_MUL  = 5'd5;
    localparam logic [4:0] OP_DIV  = 5'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6
    } state_t;

    // Opcodes are dense from 0, so legality is a single range check.
    function automatic logic op_legal(input logic [4:0] op);
        return op <= OP_DIV;
    endfunction

    function automatic logic op_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/bus_control_sequencer_if.sv
// Handshake and control lines between the sequencer (master) and the
// datapath / memory interface (slave).
interface bus_control_sequencer_if;

    logic        start;
    logic [31:0] ir;
    logic        mem_ready;
    logic [4:0]  bus_sel;
    logic        pc_in;
    logic        mar_in;
    logic        mdr_in;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        hi_in;
    logic        lo_in;
    logic        reg_in;
    logic [3:0]  reg_dst;
    logic        inc_pc;
    logic        mem_read;
    logic [4:0]  alu_op;
    logic        busy;
    logic        done;
    logic        illegal;

    modport master (
        input  start, ir, mem_ready,
        output bus_sel, pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
               reg_in, reg_dst, inc_pc, mem_read, alu_op, busy, done, illegal
    );

    modport slave (
        output start, ir, mem_ready,
        input  bus_sel, pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
               reg_in, reg_dst, inc_pc, mem_read, alu_op, busy, done, illegal
    );

endinterface

// File: rtl/bus_control_sequencer.sv
// Hardwired fetch/execute control sequencer: one state register plus a
// combinational decode of state and IR into bus select and load strobes.
module bus_control_sequencer
    import bus_ctrl_pkg::*;
(
    input  logic clock,
    input  logic clear,
    bus_control_sequencer_if.master ctl
);

    state_t     state;
    state_t     state_next;
    logic       t1_waited;
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       ir_unused;

    assign op        = ctl.ir[31:27];
    assign ra        = ctl.ir[26:23];
    assign rb        = ctl.ir[22:19];
    assign rc        = ctl.ir[18:15];
    assign ir_unused = ^ctl.ir[14:0];

    // t1_waited marks T1 cycles after the first, so the PC load fires only once.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= ST_IDLE;
            t1_waited <= 1'b0;
        end else begin
            state     <= state_next;
            t1_waited <= (state == ST_T1) && !ctl.mem_ready;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ctl.start) state_next = ST_T0;
            ST_T0:   state_next = ST_T1;
            ST_T1:   if (ctl.mem_ready) state_next = ST_T2;
            ST_T2:   state_next = ST_T3;
            ST_T3:   state_next = op_legal(op) ? ST_T4 : ST_IDLE;
            ST_T4:   state_next = ST_T5;
            ST_T5:   state_next = op_muldiv(op) ? ST_T6 : ST_IDLE;
            ST_T6:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ctl.bus_sel  = BUS_NONE;
        ctl.pc_in    = 1'b0;
        ctl.mar_in   = 1'b0;
        ctl.mdr_in   = 1'b0;
        ctl.ir_in    = 1'b0;
        ctl.y_in     = 1'b0;
        ctl.z_in     = 1'b0;
        ctl.hi_in    = 1'b0;
        ctl.lo_in    = 1'b0;
        ctl.reg_in   = 1'b0;
        ctl.reg_dst  = 4'd0;
        ctl.inc_pc   = 1'b0;
        ctl.mem_read = 1'b0;
        ctl.alu_op   = 5'd0;
        ctl.done     = 1'b0;
        ctl.illegal  = 1'b0;
        ctl.busy     = (state != ST_IDLE);
        case (state)
            ST_IDLE: ;
            ST_T0: begin
                ctl.bus_sel = BUS_PC;
                ctl.mar_in  = 1'b1;
                ctl.inc_pc  = 1'b1;
                ctl.z_in    = 1'b1;
            end
            ST_T1: begin
                ctl.bus_sel  = BUS_ZLOW;
                ctl.pc_in    = !t1_waited;
                ctl.mem_read = 1'b1;
                ctl.mdr_in   = 1'b1;
            end
            ST_T2: begin
                ctl.bus_sel = BUS_MDR;
                ctl.ir_in   = 1'b1;
            end
            // An illegal opcode still shows rb on the bus but loads nothing.
            ST_T3: begin
                ctl.bus_sel = BUS_R0 + {1'b0, rb};
                ctl.y_in    = op_legal(op);
                ctl.illegal = !op_legal(op);
            end
            ST_T4: begin
                ctl.bus_sel = (op == OP_ADDI) ? BUS_CSIGN : BUS_R0 + {1'b0, rc};
                ctl.z_in    = 1'b1;
                ctl.alu_op  = op;
            end
            ST_T5: begin
                ctl.bus_sel = BUS_ZLOW;
                ctl.reg_dst = ra;
                ctl.lo_in   = op_muldiv(op);
                ctl.reg_in  = !op_muldiv(op);
                ctl.done    = !op_muldiv(op);
            end
            ST_T6: begin
                ctl.bus_sel = BUS_ZHIGH;
                ctl.hi_in   = 1'b1;
                ctl.done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Self-checking bench for bus_control_sequencer: a per-instruction behavioural
// model builds the expected output trace, one monitor compares it every cycle.
module tb_bus_control_sequencer;

    typedef struct packed {
        logic [4:0] bus_sel;
        logic       pc_in;
        logic       mar_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       reg_in;
        logic [3:0] reg_dst;
        logic       inc_pc;
        logic       mem_read;
        logic [4:0] alu_op;
        logic       busy;
        logic       done;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t exp;
        logic mr;
    } step_t;

    typedef struct {
        int op;
        int ra;
        int rb;
        int rc;
        int waits;
    } vec_t;

    logic clock = 1'b0;
    logic clear;

    bus_control_sequencer_if bif();

    bus_control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .ctl   (bif)
    );

    always #5 clock = ~clock;

    obs_t  expq[$];
    step_t steps[$];
    int compared = 0;
    int mismatched = 0;
    int cycle = 0;
    int start_cycle = 0;
    int done_cycle = 0;
    int t0_gap = 0;
    int busy_run = 0;
    int busy_len = 0;
    int pc_in_count = 0;
    int illegal_count = 0;
    int done_count = 0;
    int write_count = 0;

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.bus_sel = 5'd22;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.bus_sel  = bif.bus_sel;
        o.pc_in    = bif.pc_in;
        o.mar_in   = bif.mar_in;
        o.mdr_in   = bif.mdr_in;
        o.ir_in    = bif.ir_in;
        o.y_in     = bif.y_in;
        o.z_in     = bif.z_in;
        o.hi_in    = bif.hi_in;
        o.lo_in    = bif.lo_in;
        o.reg_in   = bif.reg_in;
        o.reg_dst  = bif.reg_dst;
        o.inc_pc   = bif.inc_pc;
        o.mem_read = bif.mem_read;
        o.alu_op   = bif.alu_op;
        o.busy     = bif.busy;
        o.done     = bif.done;
        o.illegal  = bif.illegal;
        return o;
    endfunction

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        logic [4:0] f_op;
        logic [3:0] f_ra;
        logic [3:0] f_rb;
        logic [3:0] f_rc;
        f_op = op[4:0];
        f_ra = ra[3:0];
        f_rb = rb[3:0];
        f_rc = rc[3:0];
        return {f_op, f_ra, f_rb, f_rc, 15'h2a5c};
    endfunction

    // Expected trace from T0 onward, built phase by phase from the instruction's meaning.
    function automatic void buildModel(input logic [31:0] irv, input int waits);
        step_t st;
        obs_t  o;
        int    op;
        bit    legal;
        bit    muldiv;
        op     = int'(irv[31:27]);
        legal  = (op <= 6);
        muldiv = (op == 5) || (op == 6);
        steps.delete();
        o = '0; o.busy = 1; o.bus_sel = 5'd20; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
        st.exp = o; st.mr = 1'b1; steps.push_back(st);
        for (int w = 0; w <= waits; w++) begin
            o = '0; o.busy = 1; o.bus_sel = 5'd18; o.mem_read = 1; o.mdr_in = 1;
            o.pc_in = (w == 0);
            st.exp = o; st.mr = (w == waits); steps.push_back(st);
        end
        o = '0; o.busy = 1; o.bus_sel = 5'd21; o.ir_in = 1;
        st.exp = o; st.mr = 1'b1; steps.push_back(st);
        o = '0; o.busy = 1; o.bus_sel = {1'b0, irv[22:19]}; o.y_in = legal; o.illegal = !legal;
        st.exp = o; st.mr = 1'b1; steps.push_back(st);
        if (legal) begin
            o = '0; o.busy = 1; o.z_in = 1; o.alu_op = irv[31:27];
            o.bus_sel = (op == 4) ? 5'd23 : {1'b0, irv[18:15]};
            st.exp = o; st.mr = 1'b1; steps.push_back(st);
            o = '0; o.busy = 1; o.bus_sel = 5'd18; o.reg_dst = irv[26:23];
            o.lo_in = muldiv; o.reg_in = !muldiv; o.done = !muldiv;
            st.exp = o; st.mr = 1'b1; steps.push_back(st);
            if (muldiv) begin
                o = '0; o.busy = 1; o.bus_sel = 5'd19; o.hi_in = 1; o.done = 1;
                st.exp = o; st.mr = 1'b1; steps.push_back(st);
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one instruction; chained means the previous trailing IDLE already carried start.
    task automatic applyStimulus(input logic [31:0] irv, input int waits, input bit hold,
                                 input bit chained, input bit next_start);
        buildModel(irv, waits);
        if (!chained) begin
            @(posedge clock); #1;
            bif.ir = irv; bif.start = 1'b1; bif.mem_ready = 1'b0;
            expq.push_back(idle_obs());
        end else begin
            bif.ir = irv;
        end
        foreach (steps[i]) expq.push_back(steps[i].exp);
        for (int i = 0; i < steps.size(); i++) begin
            @(posedge clock); #1;
            bif.start = hold; bif.mem_ready = steps[i].mr;
        end
        @(posedge clock); #1;
        bif.start = next_start; bif.mem_ready = 1'b0;
        expq.push_back(idle_obs());
    endtask

    always @(negedge clock) begin
        obs_t a;
        obs_t e;
        cycle++;
        a = observe();
        if (bif.start && !bif.busy && !clear) start_cycle = cycle;
        if (a.done) begin done_cycle = cycle; done_count++; end
        if (a.busy && a.bus_sel == 5'd20 && a.mar_in) t0_gap = cycle - done_cycle;
        if (a.busy) busy_run++;
        else begin
            if (busy_run > 0) busy_len = busy_run;
            busy_run = 0;
        end
        pc_in_count   += int'(a.pc_in);
        illegal_count += int'(a.illegal);
        write_count   += int'(a.reg_in) + int'(a.hi_in) + int'(a.lo_in);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("[TB] FAIL trace cycle %0d: got 0x%07h, expected 0x%07h", cycle, a, e);
            end
        end
    end

    initial begin
        vec_t vecs[$];
        int   pc_before;
        int   ill_before;
        int   done_before;
        int   wr_before;
        int   seq[6];

        clear = 1'b1;
        bif.start = 1'b0;
        bif.mem_ready = 1'b0;
        bif.ir = '0;
        repeat (3) @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock); #1;
        checkOutput("reset bus_sel", 32'(bif.bus_sel), 32'd22);
        checkOutput("reset busy", 32'(bif.busy), 32'd0);
        checkOutput("reset outputs", 32'(observe()), 32'(idle_obs()));

        // Clear during a T1 wait.
        buildModel(mk_ir(4, 5, 4, 0), 5);
        @(posedge clock); #1;
        bif.ir = mk_ir(4, 5, 4, 0); bif.start = 1'b1; bif.mem_ready = 1'b0;
        expq.push_back(idle_obs());
        for (int i = 0; i < 3; i++) expq.push_back(steps[i].exp);
        @(posedge clock); #1; bif.start = 1'b0; bif.mem_ready = 1'b1;
        @(posedge clock); #1; bif.mem_ready = 1'b0;
        @(posedge clock); #1; clear = 1'b1;
        @(posedge clock); #1; clear = 1'b0;
        expq.push_back(idle_obs());
        expq.push_back(idle_obs());
        @(negedge clock); #1;
        checkOutput("clear busy", 32'(bif.busy), 32'd0);
        checkOutput("clear bus_sel", 32'(bif.bus_sel), 32'd22);
        checkOutput("clear outputs", 32'(observe()), 32'(idle_obs()));
        @(negedge clock); #1;

        // ADD r3 = r1 + r2.
        buildModel(mk_ir(0, 3, 1, 2), 0);
        seq = '{20, 18, 21, 1, 2, 18};
        checkOutput("model add length", 32'(steps.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("model add bus_sel[%0d]", i), 32'(steps[i].exp.bus_sel), 32'(seq[i]));
        checkOutput("model add reg_dst", 32'(steps[5].exp.reg_dst), 32'd3);
        applyStimulus(mk_ir(0, 3, 1, 2), 0, 1'b0, 1'b0, 1'b0);
        @(negedge clock); #1;
        checkOutput("add busy cycles", 32'(busy_len), 32'd6);

        // ADDI with two wait states.
        buildModel(mk_ir(4, 5, 4, 0), 2);
        checkOutput("model addi T4 bus_sel", 32'(steps[6].exp.bus_sel), 32'd23);
        checkOutput("model addi T4 alu_op", 32'(steps[6].exp.alu_op), 32'd4);
        pc_before = pc_in_count;
        applyStimulus(mk_ir(4, 5, 4, 0), 2, 1'b0, 1'b0, 1'b0);
        @(negedge clock); #1;
        checkOutput("addi pc_in count", 32'(pc_in_count - pc_before), 32'd1);
        checkOutput("addi start to done", 32'(done_cycle - start_cycle), 32'd8);

        // MUL r0 = r6 * r7.
        buildModel(mk_ir(5, 0, 6, 7), 0);
        checkOutput("model mul T5 lo_in", 32'(steps[5].exp.lo_in), 32'd1);
        checkOutput("model mul T6 bus_sel", 32'(steps[6].exp.bus_sel), 32'd19);
        applyStimulus(mk_ir(5, 0, 6, 7), 0, 1'b0, 1'b0, 1'b0);
        @(negedge clock); #1;
        checkOutput("mul busy cycles", 32'(busy_len), 32'd7);

        // Illegal opcode 15.
        ill_before = illegal_count; done_before = done_count; wr_before = write_count;
        applyStimulus(mk_ir(15, 9, 8, 7), 0, 1'b0, 1'b0, 1'b0);
        @(negedge clock); #1;
        checkOutput("illegal pulses", 32'(illegal_count - ill_before), 32'd1);
        checkOutput("illegal done", 32'(done_count - done_before), 32'd0);
        checkOutput("illegal writes", 32'(write_count - wr_before), 32'd0);
        checkOutput("illegal busy cycles", 32'(busy_len), 32'd4);

        // Two ADDs with start held high throughout.
        applyStimulus(mk_ir(0, 7, 2, 3), 0, 1'b1, 1'b0, 1'b1);
        applyStimulus(mk_ir(0, 7, 2, 3), 0, 1'b1, 1'b1, 1'b0);
        @(negedge clock); #1;
        checkOutput("back-to-back T0 gap", 32'(t0_gap), 32'd2);

        // Remaining opcodes and boundary register/opcode values.
        vecs.push_back('{1, 9, 10, 11, 1});
        vecs.push_back('{2, 15, 0, 14, 0});
        vecs.push_back('{3, 0, 15, 1, 3});
        vecs.push_back('{6, 12, 13, 3, 1});
        vecs.push_back('{4, 1, 2, 3, 0});
        vecs.push_back('{7, 4, 5, 6, 0});
        vecs.push_back('{31, 15, 15, 15, 1});
        foreach (vecs[i])
            applyStimulus(mk_ir(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc),
                          vecs[i].waits, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("expected trace drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
